bp_bimodal_pht: RTL and testbench



---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_pht_array.sv | 36 +++
 rtl/bp_bimodal_pht.sv | 75 +++++++
 tb/tb_bp_bimodal_pht.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and the 2-bit saturating counter update for the bimodal predictor.
package bp_pkg;

    typedef logic [1:0] bp_cnt2_t;

    localparam bp_cnt2_t BP_SNT       = 2'd0;
    localparam bp_cnt2_t BP_WNT       = 2'd1;
    localparam bp_cnt2_t BP_WT        = 2'd2;
    localparam bp_cnt2_t BP_ST        = 2'd3;
    localparam bp_cnt2_t BP_CNT_RESET = BP_WNT;

    function automatic bp_cnt2_t bp_cnt2_next(input bp_cnt2_t cnt, input logic taken);
        bp_cnt2_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BP_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BP_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_pht_array.sv
// Counter storage: one combinational read port, one synchronous read-modify-write
// training port, synchronous reset of every entry to weakly not-taken.
module bp_pht_array
    import bp_pkg::*;
#(
    parameter int p_entries  = 64,
    parameter int c_idx_bits = $clog2(p_entries)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [c_idx_bits-1:0] rd_idx_i,
    output bp_cnt2_t              rd_cnt_o,
    input  logic                  wr_en_i,
    input  logic [c_idx_bits-1:0] wr_idx_i,
    input  logic                  wr_taken_i
);

    bp_cnt2_t cnt_q [p_entries];
    bp_cnt2_t wr_cnt_d;

    assign rd_cnt_o = cnt_q[rd_idx_i];

    // The write port trains the entry in place, so the caller only supplies the outcome.
    assign wr_cnt_d = bp_cnt2_next(cnt_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_entries; i++) begin
                cnt_q[i] <= BP_CNT_RESET;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= wr_cnt_d;
        end
    end

endmodule

// File: rtl/bp_bimodal_pht.sv
// Bimodal branch predictor top: index slicing, optional same-cycle update forwarding
// (enabled by defining BP_BYPASS_EN), and the registered response to the next-PC mux.
module bp_bimodal_pht
    import bp_pkg::*;
#(
    parameter int p_entries = 64,
    parameter int p_pc_lsb  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    input  logic [31:0] req_pc,
    output logic        resp_val,
    output logic        resp_taken,
    input  logic        upd_val,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

    localparam int c_idx_bits = $clog2(p_entries);

    logic [c_idx_bits-1:0] req_idx;
    logic [c_idx_bits-1:0] upd_idx;
    bp_cnt2_t              rd_cnt;
    bp_cnt2_t              look_cnt;
    logic                  resp_val_q,   resp_val_d;
    logic                  resp_taken_q, resp_taken_d;
    logic                  unused_pc_bits;

    assign req_idx = req_pc[p_pc_lsb +: c_idx_bits];
    assign upd_idx = upd_pc[p_pc_lsb +: c_idx_bits];

    // PC bits outside the index slice never affect the prediction.
    assign unused_pc_bits = ^{req_pc, upd_pc};

    bp_pht_array #(
        .p_entries (p_entries),
        .c_idx_bits(c_idx_bits)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_idx_i  (req_idx),
        .rd_cnt_o  (rd_cnt),
        .wr_en_i   (upd_val),
        .wr_idx_i  (upd_idx),
        .wr_taken_i(upd_taken)
    );

    always_comb begin
        look_cnt = rd_cnt;
`ifdef BP_BYPASS_EN
        if (upd_val && (upd_idx == req_idx)) begin
            look_cnt = bp_cnt2_next(rd_cnt, upd_taken);
        end
`endif
    end

    // Idle cycles force the prediction low so the mux never sees a stale taken.
    assign resp_val_d   = req_val;
    assign resp_taken_d = req_val & look_cnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val_q   <= 1'b0;
            resp_taken_q <= 1'b0;
        end else begin
            resp_val_q   <= resp_val_d;
            resp_taken_q <= resp_taken_d;
        end
    end

    assign resp_val   = resp_val_q;
    assign resp_taken = resp_taken_q;

endmodule

// File: tb/tb_bp_bimodal_pht.sv
// Directed bench for bp_bimodal_pht (p_entries=64, p_pc_lsb=2); expectations follow
// the BP_BYPASS_EN define so the same bench serves both builds.
module tb_bp_bimodal_pht;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic [31:0] req_pc;
    logic        resp_val;
    logic        resp_taken;
    logic        upd_val;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int n_cmp;
    int n_err;

    bp_bimodal_pht #(
        .p_entries(64),
        .p_pc_lsb (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_pc    (req_pc),
        .resp_val  (resp_val),
        .resp_taken(resp_taken),
        .upd_val   (upd_val),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        req_val = 1'b1;
        req_pc  = pc;
        tick();
        req_val = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic t);
        upd_val   = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        tick();
        upd_val   = 1'b0;
    endtask

    initial begin
        logic exp_conflict;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_val   = 1'b1;
        req_pc    = 32'h100;
        upd_val   = 1'b1;
        upd_pc    = 32'h100;
        upd_taken = 1'b1;

        // Reset for two cycles with a request and update presented (both ignored).
        tick();
        tick();
        check_eq("reset_resp_val", resp_val, 0);
        check_eq("reset_resp_taken", resp_taken, 0);
        reset   = 1'b0;
        req_val = 1'b0;
        upd_val = 1'b0;

        lookup(32'h100);
        check_eq("post_reset_val", resp_val, 1);
        check_eq("post_reset_taken", resp_taken, 0);
        tick();
        check_eq("idle_val", resp_val, 0);

        // 0x200 (index 0): WNT -> WT -> ST
        update(32'h200, 1'b1);
        update(32'h200, 1'b1);
        lookup(32'h200);
        check_eq("train_taken", resp_taken, 1);
        tick();
        check_eq("idle_no_stale_taken", resp_taken, 0);
        update(32'h200, 1'b1);
        update(32'h200, 1'b0);
        lookup(32'h200);
        check_eq("st_then_nt", resp_taken, 1);
        update(32'h200, 1'b0);
        lookup(32'h200);
        check_eq("wt_then_nt", resp_taken, 0);

        // 0x40 (index 16): five not-taken saturate at SNT, then climb 0->1->2
        for (int i = 0; i < 5; i++) update(32'h40, 1'b0);
        lookup(32'h40);
        check_eq("sat_snt", resp_taken, 0);
        update(32'h40, 1'b1);
        lookup(32'h40);
        check_eq("sat_to_wnt", resp_taken, 0);
        update(32'h40, 1'b1);
        lookup(32'h40);
        check_eq("sat_to_wt", resp_taken, 1);

        // Aliasing: 0x104 and 0x204 share index 1; 0x108 (index 2) untouched
        update(32'h104, 1'b1);
        update(32'h104, 1'b1);
        lookup(32'h204);
        check_eq("alias_idx1", resp_taken, 1);
        lookup(32'h108);
        check_eq("untrained_idx2", resp_taken, 0);

        // Same-cycle update and lookup on index 3 (starts at WNT)
`ifdef BP_BYPASS_EN
        exp_conflict = 1'b1;
`else
        exp_conflict = 1'b0;
`endif
        upd_val   = 1'b1;
        upd_pc    = 32'h0C;
        upd_taken = 1'b1;
        lookup(32'h0C);
        upd_val   = 1'b0;
        check_eq("conflict_same_idx", resp_taken, {31'd0, exp_conflict});
        lookup(32'h0C);
        check_eq("conflict_followup", resp_taken, 1);

        // Different indices in the same cycle: update idx 4, lookup idx 5
        upd_val   = 1'b1;
        upd_pc    = 32'h10;
        upd_taken = 1'b1;
        lookup(32'h14);
        upd_val   = 1'b0;
        check_eq("indep_lookup", resp_taken, 0);
        lookup(32'h10);
        check_eq("indep_update", resp_taken, 1);

        // Reset mid-stream: train 0x80 (index 32) to ST, lookup as reset rises
        update(32'h80, 1'b1);
        update(32'h80, 1'b1);
        reset   = 1'b1;
        req_val = 1'b1;
        req_pc  = 32'h80;
        tick();
        check_eq("midrst_val", resp_val, 0);
        check_eq("midrst_taken", resp_taken, 0);
        tick();
        reset   = 1'b0;
        req_val = 1'b0;
        lookup(32'h80);
        check_eq("after_rst_val", resp_val, 1);
        check_eq("after_rst_0x80", resp_taken, 0);
        lookup(32'h204);
        check_eq("after_rst_alias", resp_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
